dm_main_memory: RTL and testbench



---
 rtl/dm_main_memory_if.sv | 13 +
 rtl/dm_main_memory.sv | 133 +++++++++++++
 tb/tb_dm_main_memory.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_main_memory_if.sv
// Block request/response channel between the direct-mapped cache (master)
// and its main-memory responder (slave).
interface dm_main_memory_if;
    logic [19:0] addr;
    logic [63:0] wdata;
    logic        rw;
    logic        valid;
    logic [63:0] rdata;
    logic        ready;

    modport master (output addr, wdata, rw, valid, input rdata, ready);
    modport slave  (input addr, wdata, rw, valid, output rdata, ready);
endinterface

// File: rtl/dm_main_memory.sv
// Main-memory responder: accepts one block request, waits LATENCY cycles,
// then pulses ready with the read block (writes commit at acceptance).
module dm_main_memory #(
    parameter int unsigned LATENCY       = 4,
    parameter int unsigned DEPTH_LOG2    = 18,
    parameter logic [15:0] RD_COUNT_INIT = 16'h0000,
    parameter logic [15:0] WR_COUNT_INIT = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    dm_main_memory_if.slave   bus,
    output logic [15:0]       rd_count_o,
    output logic [15:0]       wr_count_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [7:0] LOAD = 8'(LATENCY - 1);

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
    logic                   rw_q, rw_d;
    logic [63:0]            data_q, data_d;
    logic                   ready_q, ready_d;
    logic [15:0]            rd_count_q, rd_count_d;
    logic [15:0]            wr_count_q, wr_count_d;

    logic [63:0]            mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0]  req_idx;
    logic [DEPTH_LOG2-1:0]  rd_idx;
    logic                   accept;
    logic                   enter_resp;
    logic                   write_en;
    logic                   unused_addr_bits;

    assign req_idx          = bus.addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^bus.addr;

    // Next-state logic; the read index comes straight from the bus when a
    // LATENCY=1 read jumps from IDLE directly to RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rw_d       = rw_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        rd_idx     = idx_q;

        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    accept = 1'b1;
                    idx_d  = req_idx;
                    rw_d   = bus.rw;
                    cnt_d  = LOAD;
                    rd_idx = req_idx;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (rw_q) begin
                    if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
                end else begin
                    if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            ready_d = 1'b1;
            if (!rw_d) data_d = mem[rd_idx];
        end
    end

    assign write_en = accept && bus.rw;

    // Array has no reset so it can map onto plain RAM; writes survive resets.
    always_ff @(posedge clk) begin
        if (write_en) mem[req_idx] <= bus.wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            idx_q      <= '0;
            rw_q       <= 1'b0;
            data_q     <= 64'h0;
            ready_q    <= 1'b0;
            rd_count_q <= RD_COUNT_INIT;
            wr_count_q <= WR_COUNT_INIT;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rw_q       <= rw_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.rdata  = data_q;
    assign bus.ready  = ready_q;
    assign rd_count_o = rd_count_q;
    assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_dm_main_memory.sv
// Scoreboard bench for dm_main_memory: a LATENCY=4 full-depth instance and a
// LATENCY=1 shallow instance whose read counter starts near saturation.
module tb_dm_main_memory;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_main_memory_if bus4 ();
    dm_main_memory_if bus1 ();

    logic [15:0] rdCnt4, wrCnt4, rdCnt1, wrCnt1;

    dm_main_memory #(.LATENCY(4), .DEPTH_LOG2(18)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .rd_count_o(rdCnt4), .wr_count_o(wrCnt4)
    );

    dm_main_memory #(.LATENCY(1), .DEPTH_LOG2(8), .RD_COUNT_INIT(16'hFFFE)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .rd_count_o(rdCnt1), .wr_count_o(wrCnt1)
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } expT;

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    expT q4[$];
    expT q1[$];
    logic [63:0] mem4 [int];
    logic [63:0] mem1 [int];
    logic [63:0] lastRead4, lastRead1;
    logic [15:0] rdExp4, wrExp4, rdExp1, wrExp1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        expT e;
        if (bus4.ready === 1'b1) begin
            tests = tests + 1;
            if (q4.size() == 0) begin
                fails = fails + 1;
                $display("[TB] FAIL unexpected_ready4 at cycle %0d got=1 required=0", cyc);
            end else begin
                e = q4.pop_front();
                if (bus4.rdata !== e.data || cyc !== e.cyc) begin
                    fails = fails + 1;
                    $display("[TB] FAIL response4 data=%h cycle=%0d required data=%h cycle=%0d",
                             bus4.rdata, cyc, e.data, e.cyc);
                end
            end
        end
        if (bus1.ready === 1'b1) begin
            tests = tests + 1;
            if (q1.size() == 0) begin
                fails = fails + 1;
                $display("[TB] FAIL unexpected_ready1 at cycle %0d got=1 required=0", cyc);
            end else begin
                e = q1.pop_front();
                if (bus1.rdata !== e.data || cyc !== e.cyc) begin
                    fails = fails + 1;
                    $display("[TB] FAIL response1 data=%h cycle=%0d required data=%h cycle=%0d",
                             bus1.rdata, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic modelAccept(input bit one, input logic [19:0] addr, input logic [63:0] data,
                               input logic rw, input int acceptCyc);
        expT e;
        int  key;
        key = one ? int'(addr[9:2]) : int'(addr[19:2]);
        if (!one) begin
            if (rw) begin
                mem4[key] = data;
                e.data    = lastRead4;
                wrExp4    = satInc(wrExp4);
            end else begin
                e.data    = mem4.exists(key) ? mem4[key] : 64'h0;
                lastRead4 = e.data;
                rdExp4    = satInc(rdExp4);
            end
            e.cyc = acceptCyc + 3;
            q4.push_back(e);
        end else begin
            if (rw) begin
                mem1[key] = data;
                e.data    = lastRead1;
                wrExp1    = satInc(wrExp1);
            end else begin
                e.data    = mem1.exists(key) ? mem1[key] : 64'h0;
                lastRead1 = e.data;
                rdExp1    = satInc(rdExp1);
            end
            e.cyc = acceptCyc;
            q1.push_back(e);
        end
    endtask

    task automatic applyStimulus(input bit one, input logic v, input logic [19:0] addr,
                                 input logic [63:0] data, input logic rw);
        if (!one) begin
            bus4.valid = v; bus4.addr = addr; bus4.wdata = data; bus4.rw = rw;
        end else begin
            bus1.valid = v; bus1.addr = addr; bus1.wdata = data; bus1.rw = rw;
        end
    endtask

    // Called just after a negedge with the DUT idle; the request is sampled at the next edge.
    task automatic pulse(input bit one, input logic [19:0] addr, input logic [63:0] data, input logic rw);
        applyStimulus(one, 1'b1, addr, data, rw);
        modelAccept(one, addr, data, rw, cyc + 1);
        @(negedge clk);
        applyStimulus(one, 1'b0, addr, data, rw);
    endtask

    // Drain the scoreboard, then step into the mandatory IDLE cycle.
    task automatic waitDone(input bit one);
        int n;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if ((one ? q1.size() : q4.size()) == 0) break;
        end
        if (n == 40) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("[TB] FAIL timeout%0d pending=%0d required=0", one, one ? q1.size() : q4.size());
            q1.delete();
            q4.delete();
        end
        @(negedge clk);
    endtask

    task automatic resetModel();
        q4.delete();
        q1.delete();
        lastRead4 = 64'h0; lastRead1 = 64'h0;
        rdExp4 = 16'h0; wrExp4 = 16'h0;
        rdExp1 = 16'hFFFE; wrExp1 = 16'h0;
    endtask

    task automatic test_reset();
        resetModel();
        @(negedge clk);
        #1;
        tests = tests + 1;
        if ({bus4.ready, bus4.rdata, rdCnt4, wrCnt4} !== {1'b0, 64'h0, 16'h0, 16'h0}) begin
            fails = fails + 1;
            $display("[TB] FAIL reset4 ready=%b data=%h rd=%h wr=%h required 0/0/0/0",
                     bus4.ready, bus4.rdata, rdCnt4, wrCnt4);
        end
        tests = tests + 1;
        if ({bus1.ready, bus1.rdata, rdCnt1, wrCnt1} !== {1'b0, 64'h0, 16'hFFFE, 16'h0}) begin
            fails = fails + 1;
            $display("[TB] FAIL reset1 ready=%b data=%h rd=%h wr=%h required 0/0/fffe/0",
                     bus1.ready, bus1.rdata, rdCnt1, wrCnt1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_read();
        pulse(1'b0, 20'h00010, 64'h0, 1'b0);
        waitDone(1'b0);
        tests = tests + 1;
        if (rdCnt4 !== rdExp4) begin
            fails = fails + 1;
            $display("[TB] FAIL rd_count_first got=%h required=%h", rdCnt4, rdExp4);
        end
    endtask

    task automatic test_write_read();
        pulse(1'b0, 20'h12344, 64'hDEAD_BEEF_0123_4567, 1'b1);
        waitDone(1'b0);
        pulse(1'b0, 20'h12347, 64'h0, 1'b0);
        waitDone(1'b0);
        tests = tests + 1;
        if (rdCnt4 !== rdExp4 || wrCnt4 !== wrExp4) begin
            fails = fails + 1;
            $display("[TB] FAIL counts_wr_rd got rd=%h wr=%h required rd=%h wr=%h",
                     rdCnt4, wrCnt4, rdExp4, wrExp4);
        end
        repeat (3) @(negedge clk);
        tests = tests + 1;
        if (bus4.rdata !== lastRead4) begin
            fails = fails + 1;
            $display("[TB] FAIL data_hold got=%h required=%h", bus4.rdata, lastRead4);
        end
    endtask

    task automatic test_held_valid();
        int c;
        c = cyc;
        applyStimulus(1'b0, 1'b1, 20'h12344, 64'h0, 1'b0);
        modelAccept(1'b0, 20'h12344, 64'h0, 1'b0, c + 1);
        modelAccept(1'b0, 20'h12344, 64'h0, 1'b0, c + 6);
        repeat (10) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'h12344, 64'h0, 1'b0);
        waitDone(1'b0);
        tests = tests + 1;
        if (rdCnt4 !== rdExp4) begin
            fails = fails + 1;
            $display("[TB] FAIL held_rd_count got=%h required=%h", rdCnt4, rdExp4);
        end
    endtask

    task automatic test_wb_alloc();
        int c;
        c = cyc;
        pulse(1'b0, 20'h00F00, 64'h1122_3344_5566_7788, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 20'h00F00, 64'h0, 1'b0);
        modelAccept(1'b0, 20'h00F00, 64'h0, 1'b0, c + 6);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'h00F00, 64'h0, 1'b0);
        waitDone(1'b0);
        tests = tests + 1;
        if (rdCnt4 !== rdExp4 || wrCnt4 !== wrExp4) begin
            fails = fails + 1;
            $display("[TB] FAIL wb_alloc_counts got rd=%h wr=%h required rd=%h wr=%h",
                     rdCnt4, wrCnt4, rdExp4, wrExp4);
        end
    endtask

    task automatic test_reset_mid();
        bit sawReady;
        applyStimulus(1'b0, 1'b1, 20'h00020, 64'h0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'h00020, 64'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        resetModel();
        tests = tests + 1;
        if ({bus4.ready, bus4.rdata, rdCnt4, wrCnt4} !== {1'b0, 64'h0, 16'h0, 16'h0}) begin
            fails = fails + 1;
            $display("[TB] FAIL async_reset ready=%b data=%h rd=%h wr=%h required 0/0/0/0",
                     bus4.ready, bus4.rdata, rdCnt4, wrCnt4);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawReady = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus4.ready !== 1'b0) sawReady = 1'b1;
        end
        tests = tests + 1;
        if (sawReady) begin
            fails = fails + 1;
            $display("[TB] FAIL aborted_ready got=1 required=0");
        end

        applyStimulus(1'b0, 1'b1, 20'h00ABC, 64'hCAFE_F00D_0BAD_BEEF, 1'b1);
        mem4[int'(20'h00ABC >> 2)] = 64'hCAFE_F00D_0BAD_BEEF;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'h00ABC, 64'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(1'b0, 20'h00ABC, 64'h0, 1'b0);
        waitDone(1'b0);
        tests = tests + 1;
        if (rdCnt4 !== rdExp4 || wrCnt4 !== wrExp4) begin
            fails = fails + 1;
            $display("[TB] FAIL after_abort_counts got rd=%h wr=%h required rd=%h wr=%h",
                     rdCnt4, wrCnt4, rdExp4, wrExp4);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        pulse(1'b1, 20'h00404, 64'h0123_4567_89AB_CDEF, 1'b1);
        waitDone(1'b1);
        c = cyc;
        applyStimulus(1'b1, 1'b1, 20'h80004, 64'h0, 1'b0);
        modelAccept(1'b1, 20'h80004, 64'h0, 1'b0, c + 1);
        modelAccept(1'b1, 20'h80004, 64'h0, 1'b0, c + 3);
        modelAccept(1'b1, 20'h80004, 64'h0, 1'b0, c + 5);
        repeat (5) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 20'h80004, 64'h0, 1'b0);
        waitDone(1'b1);
        tests = tests + 1;
        if (rdCnt1 !== rdExp1) begin
            fails = fails + 1;
            $display("[TB] FAIL rd_count_saturate got=%h required=%h", rdCnt1, rdExp1);
        end
        tests = tests + 1;
        if (wrCnt1 !== wrExp1) begin
            fails = fails + 1;
            $display("[TB] FAIL wr_count_lat1 got=%h required=%h", wrCnt1, wrExp1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 20'h0, 64'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 20'h0, 64'h0, 1'b0);
        test_reset();
        test_reset_read();
        test_write_read();
        test_held_valid();
        test_wb_alloc();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
